booth_mul_seq: RTL

- Iterative radix-2 Booth signed multiplier for the Mini-SRC ALU MUL path; produces the 64-bit HI/LO product.
- Sits directly upstream of the carry-lookahead adder chain. Each cycle it drives the adder with the partial product and the ±multiplicand, then consumes the sum.
- One add/sub plus one arithmetic shift per cycle. Start/done handshake with the control unit.

---
 rtl/booth_mul_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// Iterative radix-2 Booth signed multiplier with a 4-bit-group carry-lookahead adder.
// Optional macro BOOTH_EARLY_TERM_EN collapses trailing pure-shift steps into one barrel shift.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             in_clk,
    input  logic             in_reset_n,
    input  logic             in_start,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int NG = WIDTH / 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   add_b;
    logic             add_cin;
    logic [WIDTH:0]   gen, prop, carry, sum;

    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] q_sh;
    logic             qm1_sh;

    // Booth recoding of {Q[0], q_m1}: subtract is A + ~M with carry-in 1.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        add_b   = '0;
        add_cin = 1'b0;
        case ({q_q[0], qm1_q})
            2'b01:   add_b = m_q;
            2'b10: begin
                add_b   = ~m_q;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    // Lookahead inside each 4-bit group, group carries ripple; the extra sign bit
    // is a plain sum bit on top and the final carry-out is never formed.
    always_comb begin
        gen      = a_q & add_b;
        prop     = a_q ^ add_b;
        carry    = '0;
        carry[0] = add_cin;
        for (int k = 0; k < NG; k++) begin
            carry[4*k+1] = gen[4*k] | (prop[4*k] & carry[4*k]);
            carry[4*k+2] = gen[4*k+1] | (prop[4*k+1] & gen[4*k])
                         | (prop[4*k+1] & prop[4*k] & carry[4*k]);
            carry[4*k+3] = gen[4*k+2] | (prop[4*k+2] & gen[4*k+1])
                         | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                         | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & carry[4*k]);
            carry[4*k+4] = gen[4*k+3] | (prop[4*k+3] & gen[4*k+2])
                         | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                         | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k])
                         | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & prop[4*k] & carry[4*k]);
        end
        sum = prop ^ carry;
    end

    assign a_sh   = {sum[WIDTH], sum[WIDTH:1]};
    assign q_sh   = {sum[0], q_q[WIDTH-1:1]};
    assign qm1_sh = q_q[0];

`ifdef BOOTH_EARLY_TERM_EN
    logic [CW-1:0]          rem;
    logic [WIDTH:0]         tail_bits;
    logic                   tail_uniform;
    logic signed [2*WIDTH+1:0] full_sh;

    // Remaining steps only look at q_m1 and the low `rem` bits of Q; if those all
    // match, each remaining step adds zero and just shifts.
    always_comb begin
        rem          = CW'(WIDTH - 1) - cnt_q;
        tail_bits    = {q_sh, qm1_sh};
        tail_uniform = (rem != '0);
        for (int i = 0; i <= WIDTH; i++) begin
            if (CW'(i) <= rem && tail_bits[i] != qm1_sh)
                tail_uniform = 1'b0;
        end
        full_sh = $signed({a_sh, q_sh, qm1_sh}) >>> rem;
    end
`endif

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    m_d     = {in_x[WIDTH-1], in_x};
                    a_d     = '0;
                    q_d     = in_y;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_sh;
                q_d   = q_sh;
                qm1_d = qm1_sh;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
`ifdef BOOTH_EARLY_TERM_EN
                else if (tail_uniform) begin
                    {a_d, q_d, qm1_d} = full_sh;
                    state_d           = S_DONE;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: datapath registers are reset too, so an aborted operation leaves nothing behind.
    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result registers load as DONE is left; the pulse and the new value appear together.
    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            out_done <= 1'b0;
            out_hi   <= '0;
            out_lo   <= '0;
        end else begin
            out_done <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                out_hi <= a_q[WIDTH-1:0];
                out_lo <= q_q;
            end
        end
    end

    assign out_busy = (state_q != S_IDLE);

endmodule
